// File: rtl/ac_store_ctrl.sv
// rtl/ac_store_ctrl.sv - accumulator store controller driving the data-RAM write port
//
// Captures the accumulator value on a store request and writes it to data
// memory, holding the write strobe for WR_LAT cycles. The write pointer
// auto-increments after each completed store so that consecutive results
// land at sequential addresses.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_store_req   store request, sampled only in IDLE
//   i_addr_load   load write pointer from i_addr_in, sampled only in IDLE
//   i_addr_in     new write pointer value
//   i_ac_in       accumulator value to store
//   o_busy        high while a store is in progress (WRITE and DONE)
//   o_store_done  one-cycle pulse when a store completes
//   o_mem_we      memory write enable, high for exactly WR_LAT cycles
//   o_mem_addr    memory write address / write pointer
//   o_mem_wdata   memory write data
//   o_elem_count  stores completed since reset or the last pointer load

module ac_store_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int WR_LAT    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_store_req,
    input  logic              i_addr_load,
    input  logic [ADDR_W-1:0] i_addr_in,
    input  logic [DATA_W-1:0] i_ac_in,
    output logic              o_busy,
    output logic              o_store_done,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [ADDR_W-1:0] o_elem_count
);

    // Wait counter only needs to hold WR_LAT-1.
    localparam int WAIT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_store_done;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [ADDR_W-1:0] r_elem_count;
    logic [WAIT_W-1:0] r_wait;

    // Asynchronous reset clears mem_we without waiting for an edge, which
    // aborts any write in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_store_done <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= ADDR_W'(BASE_ADDR);
            r_mem_wdata  <= '0;
            r_elem_count <= '0;
            r_wait       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Pointer load and store request may coincide; the
                    // store then targets the freshly loaded address.
                    if (i_addr_load) begin
                        r_mem_addr   <= i_addr_in;
                        r_elem_count <= '0;
                    end
                    if (i_store_req) begin
                        r_mem_wdata <= i_ac_in;
                        r_mem_we    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_wait      <= WAIT_W'(WR_LAT - 1);
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_wait == '0) begin
                        r_mem_we     <= 1'b0;
                        r_store_done <= 1'b1;
                        r_mem_addr   <= r_mem_addr + ADDR_W'(1);
                        r_elem_count <= r_elem_count + ADDR_W'(1);
                        r_state      <= S_DONE;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy       <= 1'b0;
                    r_store_done <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_store_done <= 1'b0;
                    r_mem_we     <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_store_done = r_store_done;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_elem_count = r_elem_count;

endmodule

// File: tb/tb_ac_store_ctrl.sv
// tb/tb_ac_store_ctrl.sv - scoreboard testbench for ac_store_ctrl
module tb_ac_store_ctrl;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 0;
    localparam int WR_LAT    = 2;

    logic              clk;
    logic              rst;
    logic              store_req;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] ac_in;
    logic              busy;
    logic              store_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] elem_count;

    ac_store_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .WR_LAT(WR_LAT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_store_req(store_req), .i_addr_load(addr_load),
        .i_addr_in(addr_in), .i_ac_in(ac_in), .o_busy(busy), .o_store_done(store_done),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_elem_count(elem_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] next_addr;
        logic [ADDR_W-1:0] next_cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    // Reference model state: write pointer and element counter.
    int   m_ptr = BASE_ADDR;
    int   m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation at the start of each write burst and
    // checks the burst, its length and the completion pulse.
    exp_t cur;
    logic in_run = 1'b0;
    int   run_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_run  = 1'b0;
            run_len = 0;
        end else if (mem_we) begin
            if (!in_run) begin
                check("write_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) cur = q.pop_front();
                in_run  = 1'b1;
                run_len = 0;
            end
            run_len++;
            check("we_addr", 32'(mem_addr), 32'(cur.addr));
            check("we_wdata", 32'(mem_wdata), 32'(cur.data));
            check("we_busy", 32'(busy), 32'd1);
            check("we_no_done", 32'(store_done), 32'd0);
        end else if (in_run) begin
            in_run = 1'b0;
            check("we_len", 32'(run_len), 32'(WR_LAT));
            check("done_pulse", 32'(store_done), 32'd1);
            check("done_busy", 32'(busy), 32'd1);
            check("done_addr", 32'(mem_addr), 32'(cur.next_addr));
            check("done_count", 32'(elem_count), 32'(cur.next_cnt));
            done_seen++;
        end else begin
            check("no_stray_done", 32'(store_done), 32'd0);
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_timeout", 32'(k < 20), 32'd1);
    endtask

    // Issue one store; optionally also load the pointer in the same cycle,
    // and optionally disturb all inputs while the write is in progress.
    task automatic do_store(input logic [DATA_W-1:0] d, input logic ld,
                            input logic [ADDR_W-1:0] a, input logic noisy);
        exp_t e;
        store_req = 1'b1;
        addr_load = ld;
        addr_in   = a;
        ac_in     = d;
        if (ld) begin
            m_ptr = int'(a);
            m_cnt = 0;
        end
        e.addr      = ADDR_W'(m_ptr);
        e.data      = d;
        m_ptr       = (m_ptr + 1) % (1 << ADDR_W);
        m_cnt       = (m_cnt + 1) % (1 << ADDR_W);
        e.next_addr = ADDR_W'(m_ptr);
        e.next_cnt  = ADDR_W'(m_cnt);
        q.push_back(e);
        done_exp++;
        @(posedge clk);
        #1;
        if (noisy) begin
            store_req = 1'b1;
            addr_load = 1'b1;
            addr_in   = ADDR_W'($urandom);
            ac_in     = ~d;
            @(posedge clk);
            #1;
            ac_in     = DATA_W'($urandom);
        end
        store_req = 1'b0;
        addr_load = 1'b0;
        wait_idle();
    endtask

    initial begin
        int ds;
        rst = 1'b1; store_req = 1'b0; addr_load = 1'b0; addr_in = '0; ac_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'(mem_addr), 32'(BASE_ADDR));
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(elem_count), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);

        // Pointer load, then a single store.
        addr_load = 1'b1; addr_in = 8'h10;
        m_ptr = 'h10; m_cnt = 0;
        @(posedge clk);
        #1 addr_load = 1'b0;
        do_store(16'h1234, 1'b0, '0, 1'b0);
        check("t2_addr", 32'(mem_addr), 32'h11);
        check("t2_count", 32'(elem_count), 32'd1);

        // Back-to-back stores at the earliest legal edge.
        for (int i = 1; i <= 4; i++) do_store(DATA_W'(i), 1'b0, '0, 1'b0);
        check("t3_addr", 32'(mem_addr), 32'h15);
        check("t3_count", 32'(elem_count), 32'd5);

        // Simultaneous load and store, then wrap-around.
        do_store(16'hBEEF, 1'b1, 8'hFF, 1'b0);
        check("t4_addr_wrap", 32'(mem_addr), 32'h00);
        check("t4_count", 32'(elem_count), 32'd1);

        // Requests and data changes during WRITE must be ignored.
        ds = done_seen;
        do_store(16'hA5C3, 1'b0, '0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_one_done", 32'(done_seen - ds), 32'd1);
        check("t5_addr", 32'(mem_addr), 32'(m_ptr));
        check("t5_count", 32'(elem_count), 32'(m_cnt));

        // Reset in the first WRITE cycle aborts without an edge.
        ds = done_seen;
        store_req = 1'b1; ac_in = 16'h7777;
        @(posedge clk);
        #1 store_req = 1'b0;
        check("t6_we_before", 32'(mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_we_async", 32'(mem_we), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_addr", 32'(mem_addr), 32'(BASE_ADDR));
        check("t6_count", 32'(elem_count), 32'd0);
        check("t6_wdata", 32'(mem_wdata), 32'd0);
        check("t6_done", 32'(store_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = BASE_ADDR; m_cnt = 0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_done", 32'(done_seen - ds), 32'd0);

        // Randomized stores with occasional pointer loads and idle gaps.
        for (int i = 0; i < 40; i++) begin
            do_store(DATA_W'($urandom), 1'($urandom_range(0, 3) == 0),
                     ADDR_W'($urandom), 1'($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check("rnd_addr", 32'(mem_addr), 32'(m_ptr));
            check("rnd_count", 32'(elem_count), 32'(m_cnt));
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(q.size()), 32'd0);
        check("final_done_total", 32'(done_seen), 32'(done_exp - 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ac_store_ctrl.md
Name: ac_store_ctrl

Overview:
Writer-side companion to the accumulator register. It captures the 16-bit accumulator value on a store request and writes it into data memory. The write strobe is held for a fixed number of cycles, and the write address auto-increments after each write so that result-matrix elements are stored sequentially. It sits between the accumulator output and the data-RAM write port and is driven by the control unit.

Parameters:
DATA_W, 16, width of the accumulator value and the memory write data
ADDR_W, 8, width of the memory address and the element counter
BASE_ADDR, 0, value of mem_addr after reset
WR_LAT, 2, number of cycles mem_we is held per write (must be >= 1)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
store_req  in  1  request to store ac_in; sampled only in IDLE
addr_load  in  1  load the write pointer from addr_in; sampled only in IDLE
addr_in  in  ADDR_W  new write address
ac_in  in  DATA_W  accumulator value to store
busy  out  1  high while a store is in progress
store_done  out  1  one-cycle pulse when a store completes
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory write address (also the write pointer)
mem_wdata  out  DATA_W  memory write data
elem_count  out  ADDR_W  number of stores completed since reset or the last addr_load

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state = IDLE, busy = 0, store_done = 0, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0, elem_count = 0. Asserting rst mid-write aborts the write immediately; mem_we drops without waiting for a clock edge.
- All outputs are registered.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - addr_load = 1: mem_addr <= addr_in, elem_count <= 0.
  - store_req = 1: mem_wdata <= ac_in, mem_we <= 1, busy <= 1, wait counter <= WR_LAT-1, go to WRITE.
  - Both asserted in the same cycle: both take effect; the write targets addr_in and elem_count restarts at 0.
- WRITE:
  - mem_we = 1; mem_addr and mem_wdata held stable.
  - Wait counter decrements each cycle. On the cycle the counter reaches 0: mem_we <= 0, store_done <= 1, mem_addr <= mem_addr + 1, elem_count <= elem_count + 1, go to DONE.
  - mem_we is therefore high for exactly WR_LAT cycles.
- DONE:
  - store_done = 1 and busy = 1 for this one cycle.
  - Next state IDLE; busy <= 0, store_done <= 0.
- store_req and addr_load are ignored in WRITE and DONE; they are not queued.
- Latency: request sampled at edge E0 -> mem_we high from E0 to E0+WR_LAT -> store_done high from E0+WR_LAT to E0+WR_LAT+1 -> earliest next request sampled at edge E0+WR_LAT+2.
- Wrap-around: mem_addr and elem_count increment modulo 2^ADDR_W. No overflow flag.
- ac_in may change after the request edge without affecting the write in progress.

Test Plan:
1. Reset, then idle 3 cycles -> mem_addr = BASE_ADDR (0), mem_we = 0, busy = 0, elem_count = 0.
2. addr_load with addr_in = 0x10; then store_req with ac_in = 0x1234 (WR_LAT = 2) -> mem_we high exactly 2 cycles with mem_addr = 0x10 and mem_wdata = 0x1234; then store_done pulses 1 cycle; afterwards mem_addr = 0x11, elem_count = 1.
3. Four back-to-back stores of 0x0001..0x0004, each issued as soon as busy drops -> writes to 0x11..0x14 in order; elem_count = 5; no request lost when issued at the earliest legal edge.
4. addr_load (addr_in = 0xFF) and store_req (ac_in = 0xBEEF) in the same cycle -> write lands at 0xFF; mem_addr then wraps to 0x00; elem_count = 1.
5. store_req and addr_load pulsed during WRITE, and ac_in changed mid-write -> both requests ignored; mem_wdata stays at the captured value; exactly one store_done.
6. Assert rst during the first WRITE cycle -> mem_we drops immediately, before the next edge; all outputs return to reset values; no store_done pulse.
